// File: rtl/ahb_rr_ctrl.sv
// Round-robin arbitrated single-transfer AHB controller for NumReq valid/ack requesters.
// A slot holds the address phase, D slot the data phase; both advance on ready.
module ahb_rr_ctrl #(
  parameter int   DataWidth = 32,
  parameter int   AddrWidth = 32,
  parameter int   NumReq    = 4,
  parameter logic NonSec    = 1'b1
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [NumReq-1:0]             reqValid,
  input  logic [NumReq*AddrWidth-1:0]   reqAddr,
  input  logic [NumReq-1:0]             reqWrite,
  input  logic [NumReq*3-1:0]           reqSize,
  input  logic [NumReq*DataWidth-1:0]   reqWData,
  input  logic [NumReq*DataWidth/8-1:0] reqWStrb,
  output logic [NumReq-1:0]             reqAck,
  output logic [NumReq-1:0]             respValid,
  output logic [DataWidth-1:0]          respData,
  output logic                          respErr,
  output logic [AddrWidth-1:0]          addr,
  output logic [2:0]                    size,
  output logic                          write,
  output logic [1:0]                    trans,
  output logic [2:0]                    burst,
  output logic                          mastLock,
  output logic                          nonSec,
  output logic [DataWidth-1:0]          wData,
  output logic [DataWidth/8-1:0]        wStrb,
  input  logic [DataWidth-1:0]          rData,
  input  logic                          ready,
  input  logic                          resp
);

  localparam int StrbW = DataWidth / 8;
  localparam int OwnW  = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic                 aValid_q, aValid_d;
  logic [OwnW-1:0]      aOwner_q, aOwner_d;
  logic [AddrWidth-1:0] aAddr_q, aAddr_d;
  logic [2:0]           aSize_q, aSize_d;
  logic                 aWrite_q, aWrite_d;
  logic [DataWidth-1:0] aWData_q, aWData_d;
  logic [StrbW-1:0]     aWStrb_q, aWStrb_d;
  logic                 dValid_q, dValid_d;
  logic [OwnW-1:0]      dOwner_q, dOwner_d;
  logic                 dWrite_q, dWrite_d;
  logic [DataWidth-1:0] dWData_q, dWData_d;
  logic [StrbW-1:0]     dWStrb_q, dWStrb_d;
  logic [OwnW-1:0]      last_q, last_d;
  logic [NumReq-1:0]    respValid_q, respValid_d;
  logic [DataWidth-1:0] respData_q, respData_d;
  logic                 respErr_q, respErr_d;

  logic                 addrAcc, dataDone, errCancel, aLoad, winFound;
  logic [OwnW-1:0]      winIdx;
  logic [NumReq-1:0]    cand;

  assign addrAcc   = aValid_q & ready;
  assign dataDone  = dValid_q & ready;
  // First cycle of an ERROR response: abandon the pending address phase so IDLE goes out next.
  assign errCancel = dValid_q & resp & ~ready & aValid_q;
  assign aLoad     = ~aValid_q | addrAcc;

  always_comb begin
    reqAck = '0;
    for (int i = 0; i < NumReq; i++) begin
      reqAck[i] = addrAcc && (aOwner_q == OwnW'(i));
    end
    cand = reqValid & ~reqAck;
  end

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    for (int i = 1; i <= NumReq; i++) begin
      int k;
      k = int'(last_q) + i;
      if (k >= NumReq) k = k - NumReq;
      if (!winFound && cand[k]) begin
        winFound = 1'b1;
        winIdx   = OwnW'(k);
      end
    end
  end

  always_comb begin
    int w;
    w           = int'(winIdx);
    aValid_d    = aValid_q;
    aOwner_d    = aOwner_q;
    aAddr_d     = aAddr_q;
    aSize_d     = aSize_q;
    aWrite_d    = aWrite_q;
    aWData_d    = aWData_q;
    aWStrb_d    = aWStrb_q;
    last_d      = last_q;
    dValid_d    = dValid_q;
    dOwner_d    = dOwner_q;
    dWrite_d    = dWrite_q;
    dWData_d    = dWData_q;
    dWStrb_d    = dWStrb_q;
    respValid_d = '0;
    respData_d  = respData_q;
    respErr_d   = respErr_q;

    if (errCancel) begin
      aValid_d = 1'b0;
    end else if (aLoad) begin
      aValid_d = winFound;
      if (winFound) begin
        aOwner_d = winIdx;
        aAddr_d  = reqAddr[w*AddrWidth +: AddrWidth];
        aSize_d  = reqSize[w*3 +: 3];
        aWrite_d = reqWrite[w];
        aWData_d = reqWData[w*DataWidth +: DataWidth];
        aWStrb_d = reqWStrb[w*StrbW +: StrbW];
        last_d   = winIdx;
      end
    end

    if (addrAcc) begin
      dValid_d = 1'b1;
      dOwner_d = aOwner_q;
      dWrite_d = aWrite_q;
      dWData_d = aWData_q;
      dWStrb_d = aWStrb_q;
    end else if (dataDone) begin
      dValid_d = 1'b0;
    end

    if (dataDone) begin
      respValid_d[dOwner_q] = 1'b1;
      respData_d            = dWrite_q ? '0 : rData;
      respErr_d             = resp;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      aValid_q    <= 1'b0;
      aOwner_q    <= '0;
      aAddr_q     <= '0;
      aSize_q     <= '0;
      aWrite_q    <= 1'b0;
      aWData_q    <= '0;
      aWStrb_q    <= '0;
      dValid_q    <= 1'b0;
      dOwner_q    <= '0;
      dWrite_q    <= 1'b0;
      dWData_q    <= '0;
      dWStrb_q    <= '0;
      last_q      <= OwnW'(NumReq - 1);
      respValid_q <= '0;
      respData_q  <= '0;
      respErr_q   <= 1'b0;
    end else begin
      aValid_q    <= aValid_d;
      aOwner_q    <= aOwner_d;
      aAddr_q     <= aAddr_d;
      aSize_q     <= aSize_d;
      aWrite_q    <= aWrite_d;
      aWData_q    <= aWData_d;
      aWStrb_q    <= aWStrb_d;
      dValid_q    <= dValid_d;
      dOwner_q    <= dOwner_d;
      dWrite_q    <= dWrite_d;
      dWData_q    <= dWData_d;
      dWStrb_q    <= dWStrb_d;
      last_q      <= last_d;
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
      respErr_q   <= respErr_d;
    end
  end

  assign trans     = aValid_q ? 2'b10 : 2'b00;
  assign addr      = aAddr_q;
  assign size      = aSize_q;
  assign write     = aWrite_q;
  assign burst     = 3'b000;
  assign mastLock  = 1'b0;
  assign nonSec    = NonSec;
  assign wData     = dWData_q;
  assign wStrb     = dWStrb_q;
  assign respValid = respValid_q;
  assign respData  = respData_q;
  assign respErr   = respErr_q;

endmodule

// File: tb/tb_ahb_rr_ctrl.sv
// Directed bench for ahb_rr_ctrl: latency, back-to-back, stall, error, fairness, reset.
module tb_ahb_rr_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              nReset;
  logic [NR-1:0]     reqValid;
  logic [NR*AW-1:0]  reqAddr;
  logic [NR-1:0]     reqWrite;
  logic [NR*3-1:0]   reqSize;
  logic [NR*DW-1:0]  reqWData;
  logic [NR*DW/8-1:0] reqWStrb;
  logic [NR-1:0]     reqAck, respValid;
  logic [DW-1:0]     respData, rData, wData;
  logic              respErr, write, mastLock, nonSec, ready, resp;
  logic [AW-1:0]     addr;
  logic [2:0]        size, burst;
  logic [1:0]        trans;
  logic [DW/8-1:0]   wStrb;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ahb_rr_ctrl #(.DataWidth(DW), .AddrWidth(AW), .NumReq(NR), .NonSec(1'b1)) dut (
    .clk(clk), .nReset(nReset),
    .reqValid(reqValid), .reqAddr(reqAddr), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqWData(reqWData), .reqWStrb(reqWStrb),
    .reqAck(reqAck), .respValid(respValid), .respData(respData), .respErr(respErr),
    .addr(addr), .size(size), .write(write), .trans(trans), .burst(burst),
    .mastLock(mastLock), .nonSec(nonSec), .wData(wData), .wStrb(wStrb),
    .rData(rData), .ready(ready), .resp(resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    reqAddr[i*AW +: AW]    = a;
    reqWrite[i]            = w;
    reqSize[i*3 +: 3]      = 3'b010;
    reqWData[i*DW +: DW]   = d;
    reqWStrb[i*4 +: 4]     = 4'hF;
  endtask

  task automatic idle(input int n);
    reqValid = '0;
    repeat (n) step();
  endtask

  initial begin
    nReset = 1'b0; reqValid = '0; reqAddr = '0; reqWrite = '0; reqSize = '0;
    reqWData = '0; reqWStrb = '0; rData = '0; ready = 1'b1; resp = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_trans", trans, 2'b00);
    chk("rst_addr", addr, 0);
    chk("rst_size", size, 0);
    chk("rst_write", write, 0);
    chk("rst_wdata", wData, 0);
    chk("rst_wstrb", wStrb, 0);
    chk("rst_burst", burst, 0);
    chk("rst_lock", mastLock, 0);
    chk("rst_nonsec", nonSec, 1);
    chk("rst_ack", reqAck, 0);
    chk("rst_resp", respValid, 0);
    chk("rst_rdata", respData, 0);
    chk("rst_err", respErr, 0);
    nReset = 1'b1;

    // four simultaneous writes
    step();
    for (int i = 0; i < NR; i++) setreq(i, 32'h200 + i*16, 1'b1, 32'hA000_0000 + i);
    reqValid = 4'hF;
    #1;
    chk("b2b_c0_idle", trans, 2'b00);
    for (int i = 0; i < NR; i++) begin
      step();
      chk("b2b_ack", reqAck, 4'b0001 << i);
      chk("b2b_trans", trans, 2'b10);
      chk("b2b_addr", addr, 32'h200 + i*16);
      chk("b2b_write", write, 1);
      if (i > 0) chk("b2b_wdata", wData, 32'hA000_0000 + i - 1);
      if (i > 1) chk("b2b_resp", respValid, 4'b0001 << (i-2));
      reqValid[i] = 1'b0;
    end
    step();
    chk("b2b_c5_idle", trans, 2'b00);
    chk("b2b_c5_wdata", wData, 32'hA000_0003);
    chk("b2b_c5_resp", respValid, 4'b0100);
    step();
    chk("b2b_c6_resp", respValid, 4'b1000);
    chk("b2b_c6_data", respData, 0);
    idle(2);

    // single read, minimum latency
    step();
    setreq(0, 32'h100, 1'b0, 32'h0);
    reqValid = 4'b0001;
    #1;
    chk("rd_c0_idle", trans, 2'b00);
    step();
    chk("rd_c1_trans", trans, 2'b10);
    chk("rd_c1_addr", addr, 32'h100);
    chk("rd_c1_write", write, 0);
    chk("rd_c1_size", size, 3'b010);
    chk("rd_c1_ack", reqAck, 4'b0001);
    reqValid = '0;
    step();
    rData = 32'hDEAD_BEEF;
    #1;
    chk("rd_c2_ack", reqAck, 0);
    chk("rd_c2_idle", trans, 2'b00);
    chk("rd_c2_resp", respValid, 0);
    step();
    rData = '0;
    #1;
    chk("rd_c3_resp", respValid, 4'b0001);
    chk("rd_c3_data", respData, 32'hDEAD_BEEF);
    chk("rd_c3_err", respErr, 0);
    step();
    chk("rd_c4_resp", respValid, 0);
    idle(1);

    // stall with requester 1 in the address phase
    step();
    setreq(0, 32'h300, 1'b0, 0); setreq(1, 32'h310, 1'b0, 0); setreq(3, 32'h330, 1'b0, 0);
    reqValid = 4'b0001;
    step();
    chk("st_c1_ack", reqAck, 4'b0001);
    reqValid = 4'b0010;
    step();
    ready = 1'b0; reqValid[3] = 1'b1;
    #1;
    chk("st_c2_addr", addr, 32'h310);
    chk("st_c2_trans", trans, 2'b10);
    chk("st_c2_ack", reqAck, 0);
    step();
    chk("st_c3_addr", addr, 32'h310);
    chk("st_c3_ack", reqAck, 0);
    chk("st_c3_resp", respValid, 0);
    step();
    ready = 1'b1; rData = 32'h1111_0000;
    #1;
    chk("st_c4_ack", reqAck, 4'b0010);
    chk("st_c4_resp", respValid, 0);
    reqValid[1] = 1'b0;
    step();
    rData = 32'h1111_0001;
    #1;
    chk("st_c5_resp", respValid, 4'b0001);
    chk("st_c5_data", respData, 32'h1111_0000);
    chk("st_c5_ack", reqAck, 4'b1000);
    chk("st_c5_addr", addr, 32'h330);
    reqValid[3] = 1'b0;
    step();
    rData = 32'h1111_0003;
    #1;
    chk("st_c6_resp", respValid, 4'b0010);
    chk("st_c6_data", respData, 32'h1111_0001);
    step();
    rData = '0;
    #1;
    chk("st_c7_resp", respValid, 4'b1000);
    chk("st_c7_data", respData, 32'h1111_0003);
    idle(1);

    // two-cycle error response with requester 2 waiting in the A slot
    step();
    setreq(0, 32'h400, 1'b0, 0); setreq(2, 32'h420, 1'b0, 0);
    reqValid = 4'b0001;
    step();
    chk("er_c1_ack", reqAck, 4'b0001);
    reqValid = 4'b0100;
    step();
    ready = 1'b0; resp = 1'b1;
    #1;
    chk("er_c2_trans", trans, 2'b10);
    chk("er_c2_addr", addr, 32'h420);
    chk("er_c2_ack", reqAck, 0);
    step();
    ready = 1'b1; resp = 1'b1; rData = 32'h0BAD_0BAD;
    #1;
    chk("er_c3_idle", trans, 2'b00);
    chk("er_c3_ack", reqAck, 0);
    chk("er_c3_resp", respValid, 0);
    step();
    resp = 1'b0; rData = '0;
    #1;
    chk("er_c4_resp", respValid, 4'b0001);
    chk("er_c4_err", respErr, 1);
    chk("er_c4_data", respData, 32'h0BAD_0BAD);
    chk("er_c4_trans", trans, 2'b10);
    chk("er_c4_addr", addr, 32'h420);
    chk("er_c4_ack", reqAck, 4'b0100);
    reqValid = '0;
    step();
    rData = 32'h2222_0002;
    #1;
    chk("er_c5_resp", respValid, 0);
    step();
    rData = '0;
    #1;
    chk("er_c6_resp", respValid, 4'b0100);
    chk("er_c6_err", respErr, 0);
    chk("er_c6_data", respData, 32'h2222_0002);
    step();
    chk("er_c7_resp", respValid, 0);
    idle(1);

    // reset pulse in the middle of back-to-back writes
    step();
    setreq(1, 32'h510, 1'b1, 32'hB1); setreq(2, 32'h520, 1'b1, 32'hB2);
    reqValid = 4'b0110;
    step();
    chk("mr_c1_ack", reqAck, 4'b0010);
    step();
    chk("mr_c2_ack", reqAck, 4'b0100);
    chk("mr_c2_wdata", wData, 32'hB1);
    step();
    chk("mr_c3_ack", reqAck, 4'b0010);
    chk("mr_c3_wdata", wData, 32'hB2);
    chk("mr_c3_resp", respValid, 4'b0010);
    nReset = 1'b0;
    #1;
    chk("mr_trans", trans, 2'b00);
    chk("mr_addr", addr, 0);
    chk("mr_wdata", wData, 0);
    chk("mr_wstrb", wStrb, 0);
    chk("mr_write", write, 0);
    chk("mr_ack", reqAck, 0);
    chk("mr_resp", respValid, 0);
    setreq(0, 32'h500, 1'b0, 0); setreq(3, 32'h530, 1'b0, 0);
    reqValid = 4'b1001;

    // fairness between requesters 0 and 3 right out of reset
    step();
    nReset = 1'b1;
    #1;
    chk("fa_f0_idle", trans, 2'b00);
    chk("fa_f0_resp", respValid, 0);
    step();
    chk("fa_f1_ack", reqAck, 4'b0001);
    chk("fa_f1_addr", addr, 32'h500);
    chk("fa_f1_resp", respValid, 0);
    step();
    chk("fa_f2_ack", reqAck, 4'b1000);
    chk("fa_f2_addr", addr, 32'h530);
    chk("fa_f2_resp", respValid, 0);
    step();
    chk("fa_f3_ack", reqAck, 4'b0001);
    chk("fa_f3_resp", respValid, 4'b0001);
    step();
    chk("fa_f4_ack", reqAck, 4'b1000);
    chk("fa_f4_resp", respValid, 4'b1000);
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ahb_rr_ctrl.md
# ahb_rr_ctrl

Single-transfer AHB controller that shares one `AHBCommon_if`-style controller port between `NumReq` simple requesters with round-robin arbitration. Each requester presents one word-or-smaller transfer through a valid/ack request channel and receives a registered response pulse. The block drives the AHB address and data phases with full address/data pipelining, so back-to-back transfers from different requesters issue without idle cycles. It sits between processor-side or DMA-side clients and the AHB decoder/mux fabric.

## Interface
- `DataWidth`, 32, data bus width; must be a multiple of 8
- `AddrWidth`, 32, address width
- `NumReq`, 4, number of requesters, 2..8
- `NonSec`, 1'b1, constant value driven on `nonSec`
- `clk` in 1: clock; all state updates on the rising edge
- `nReset` in 1: reset, asynchronous and active-low
- `reqValid` in NumReq: requester i has a pending transfer; fields stable until `reqAck[i]`
- `reqAddr` in NumReq*AddrWidth: packed byte addresses, slice i belongs to requester i
- `reqWrite` in NumReq: 1 write, 0 read
- `reqSize` in NumReq*3: AHB size encoding
- `reqWData` in NumReq*DataWidth: write data
- `reqWStrb` in NumReq*DataWidth/8: write strobes
- `reqAck` out NumReq: one-hot pulse; address phase of requester i accepted this cycle
- `respValid` out NumReq: one-hot registered pulse; transfer of requester i finished
- `respData` out DataWidth: read data captured with `respValid`
- `respErr` out 1: error response, qualified by `respValid`
- `addr` out AddrWidth, `size` out 3, `write` out 1: AHB address-phase controls
- `trans` out 2: 2'b00 IDLE, 2'b10 NONSEQ; no other codes driven
- `burst` out 3: constant 3'b000 (SINGLE); `mastLock` out 1: constant 0; `nonSec` out 1: constant `NonSec`
- `wData` out DataWidth, `wStrb` out DataWidth/8: data-phase write data
- `rData` in DataWidth, `ready` in 1, `resp` in 1: AHB returns from the mux

## Operation
- Two pipeline slots, each with a valid bit and an owner index. A slot: `aValid`, `aOwner`, plus registered addr/size/write/wData/wStrb. D slot: `dValid`, `dOwner`, `dWrite`, registered wData/wStrb.
- `trans` = NONSEQ iff `aValid`, else IDLE. `addr`/`size`/`write` come from the A-slot registers and hold their last values when IDLE. `wData`/`wStrb` come from the D-slot registers.
- Address accept: `aValid & ready`. `reqAck[aOwner]` is combinational on that condition. On the edge, A moves into D: `dValid`=1, `dOwner`=`aOwner`.
- Data complete: `dValid & ready`. On the edge, `respValid[dOwner]`=1, `respData`=`rData` (reads) or 0 (writes), `respErr`=`resp`. `dValid` clears unless refilled by A in the same cycle.
- The A slot is loadable when `!aValid`, or on an address accept. Candidates are `reqValid` with the bit of the requester acked this cycle masked. The winner is the first candidate searching upward from `(last+1) mod NumReq`, where `last` is the last loaded owner (reset: NumReq-1). The winner's fields are loaded and `last` is updated.
- Error, two-cycle AHB response: when `dValid & resp & !ready` and `aValid`, the next cycle drives IDLE. `aValid` clears, no ack is given, and that request stays pending for re-arbitration. In the same cycle a requester's `reqValid` may drop only after its ack.
- While `aValid & !ready`, the A-slot contents and owner are frozen (AHB stability), whatever happens on `reqValid`.

## Timing
- Reset (async assert, sync release): `trans`=IDLE; `addr`, `size`, `write`, `wData`, `wStrb` = 0; `burst`=0, `mastLock`=0, `nonSec`=`NonSec`; `reqAck`=0, `respValid`=0, `respData`=0, `respErr`=0; both slots invalid; `last`=NumReq-1.
- Reset mid-transfer drops both slots without any `respValid`. Pending requesters must still hold `reqValid` to be re-served.
- Minimum latency with `ready`=1: `reqValid` rises at cycle 0, NONSEQ and `reqAck` at cycle 1, data phase at cycle 2, `respValid` at cycle 3.
- Throughput is one transfer per cycle with continuous NONSEQ when requests are pending and `ready`=1.
- Each `ready`=0 cycle stretches both phases by one cycle.

## Test plan
- Single read, requester 0, addr 0x100, `rData`=0xDEADBEEF, `ready`=1 → NONSEQ at c1 with addr 0x100 and `write`=0, `reqAck`=0001 at c1, `respValid`=0001 with data 0xDEADBEEF at c3.
- All four requesters request writes at c0 → acks in order 0,1,2,3 on consecutive cycles, `trans` NONSEQ for 4 straight cycles, each `wData` appearing one cycle after its ack.
- Read with `ready` low for 2 data-phase cycles while requester 1 is in the A slot → `addr` and `aOwner` unchanged during the stall, `respValid` delayed 2 cycles, order preserved.
- Error: data phase returns resp=1/ready=0 then resp=1/ready=1, with requester 2 in the A slot → IDLE on the second cycle, `respErr`=1 for the first owner, requester 2 re-acked later, no lost or duplicated responses.
- Fairness: requesters 0 and 3 held permanently valid → grants alternate 0,3,0,3.
- `nReset` pulsed mid back-to-back traffic → all outputs return to reset values immediately, no `respValid` for in-flight transfers, arbitration restarts at requester 0.
